cdc_hs_mbit_f2s: RTL and testbench

- Parametrised multi-bit clock-domain crossing from the fast clk_b domain to the slow clk_a domain.
- Uses a toggle request/acknowledge handshake, replacing one-way pulse-toggle transfer with no flow control.
- The source side gets a valid/ready interface, so no word is lost when the slow domain cannot keep up.
- Sits between fast-domain producers (config/status words, sample snapshots) and slow-domain consumers.

---
 rtl/cdc_hs_mbit_f2s_pkg.sv | 24 ++
 rtl/cdc_hs_mbit_f2s_if.sv | 27 ++
 rtl/cdc_hs_mbit_f2s_sync.sv | 28 ++
 rtl/cdc_hs_mbit_f2s.sv | 172 +++++++++++++++++
 tb/tb_cdc_hs_mbit_f2s.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_hs_mbit_f2s_pkg.sv
// Shared constants and types for the fast-to-slow multi-bit handshake crossing.
// Optional stall counter in the top is enabled by the CDC_STALL_CNT_EN macro.
package cdc_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } src_state_e;

    // Out-of-range stage counts are pulled into the supported window.
    function automatic int sync_stages_legal(input int stages);
        if (stages < SYNC_STAGES_MIN) begin
            return SYNC_STAGES_MIN;
        end else if (stages > SYNC_STAGES_MAX) begin
            return SYNC_STAGES_MAX;
        end else begin
            return stages;
        end
    endfunction

endpackage

// File: rtl/cdc_hs_mbit_f2s_if.sv
// Source valid/ready handshake and destination delivery bus of the crossing.
// The slave modport is the crossing itself; master is the surrounding logic.
interface cdc_hs_mbit_f2s_if #(
    parameter int WIDTH = 8
);
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ready;
    logic             dst_valid;
    logic [WIDTH-1:0] dst_data;

    modport master (
        output src_valid,
        output src_data,
        input  src_ready,
        input  dst_valid,
        input  dst_data
    );

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready,
        output dst_valid,
        output dst_data
    );
endinterface

// File: rtl/cdc_hs_mbit_f2s_sync.sv
// Single-bit synchroniser chain with asynchronous active-low reset.
// Used for the request toggle (into clk_a) and the acknowledge toggle (into clk_b).
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int STAGES  = SYNC_STAGES_MIN,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/cdc_hs_mbit_f2s.sv
// Multi-bit clk_b -> clk_a crossing with toggle request/acknowledge handshake.
// Optional feature: CDC_STALL_CNT_EN adds the saturating stall_cnt output.
module cdc_hs_mbit_f2s
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_b,
    input  logic                 brstn,
    input  logic                 clk_a,
    input  logic                 arstn,
    cdc_hs_mbit_f2s_if.slave     bus
`ifdef CDC_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    localparam int STG_C = sync_stages_legal(SYNC_STAGES);

    // clk_b domain
    src_state_e       state_r;
    src_state_e       state_nxt_s;
    logic             src_ready_r;
    logic             ready_nxt_s;
    logic             accept_s;
    logic             req_tgl_r;
    logic             ack_sync_s;
    logic [WIDTH-1:0] hold_reg_r;

    // clk_a domain
    logic             req_sync_s;
    logic             req_hist_r;
    logic             new_req_s;
    logic             ack_tgl_r;
    logic             dst_valid_r;
    logic [WIDTH-1:0] dst_data_r;

    // source FSM state and registered ready decode
    always_ff @(posedge clk_b or negedge brstn) begin
        if (!brstn) begin
            state_r     <= IDLE;
            src_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            src_ready_r <= ready_nxt_s;
        end
    end

    // source FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (ack_sync_s == req_tgl_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // source FSM outputs: acceptance strobe and next-cycle ready
    always_comb begin
        accept_s    = 1'b0;
        ready_nxt_s = 1'b0;
        if (bus.src_valid && src_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (state_nxt_s == IDLE) begin
            ready_nxt_s = 1'b1;
        end else begin
            ready_nxt_s = 1'b0;
        end
    end

    // capture the word and flip the request toggle on acceptance
    always_ff @(posedge clk_b or negedge brstn) begin
        if (!brstn) begin
            hold_reg_r <= '0;
            req_tgl_r  <= 1'b0;
        end else if (accept_s) begin
            hold_reg_r <= bus.src_data;
            req_tgl_r  <= ~req_tgl_r;
        end else begin
            hold_reg_r <= hold_reg_r;
            req_tgl_r  <= req_tgl_r;
        end
    end

    cdc_sync_bit #(
        .STAGES  (STG_C),
        .RST_VAL (1'b0)
    ) u_req_sync (
        .clk  (clk_a),
        .rstn (arstn),
        .d    (req_tgl_r),
        .q    (req_sync_s)
    );

    assign new_req_s = req_sync_s ^ req_hist_r;

    // hold_reg is stable for the whole BUSY window, so it is sampled directly here
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            req_hist_r  <= 1'b0;
            dst_valid_r <= 1'b0;
            dst_data_r  <= '0;
            ack_tgl_r   <= 1'b0;
        end else begin
            req_hist_r  <= req_sync_s;
            dst_valid_r <= new_req_s;
            if (new_req_s) begin
                dst_data_r <= hold_reg_r;
                ack_tgl_r  <= ~ack_tgl_r;
            end else begin
                dst_data_r <= dst_data_r;
                ack_tgl_r  <= ack_tgl_r;
            end
        end
    end

    cdc_sync_bit #(
        .STAGES  (STG_C),
        .RST_VAL (1'b0)
    ) u_ack_sync (
        .clk  (clk_b),
        .rstn (brstn),
        .d    (ack_tgl_r),
        .q    (ack_sync_s)
    );

    assign bus.src_ready = src_ready_r;
    assign bus.dst_valid = dst_valid_r;
    assign bus.dst_data  = dst_data_r;

`ifdef CDC_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // saturating count of cycles where the producer is held off
    always_ff @(posedge clk_b or negedge brstn) begin
        if (!brstn) begin
            stall_cnt_r <= '0;
        end else if (bus.src_valid && !src_ready_r && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    logic unused_cnt_w_s;
    assign unused_cnt_w_s = (CNT_W > 32'sd0);
`endif

endmodule

// File: tb/tb_cdc_hs_mbit_f2s.sv
// Directed self-checking bench for cdc_hs_mbit_f2s (clk_b 100 MHz, clk_a ~30 MHz).
// Build with CDC_STALL_CNT_EN defined to also exercise the stall counter (CNT_W=4).
module tb_cdc_hs_mbit_f2s;

    logic clk_b = 1'b0;
    logic clk_a = 1'b0;
    logic brstn = 1'b0;
    logic arstn = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         viol      = 0;
    logic [7:0] prev_dst  = 8'h00;
    bit         have_prev = 1'b0;

    cdc_hs_mbit_f2s_if #(.WIDTH(8)) bus ();

`ifdef CDC_STALL_CNT_EN
    logic [3:0] stall_cnt;
`endif

    cdc_hs_mbit_f2s #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) dut (
        .clk_b     (clk_b),
        .brstn     (brstn),
        .clk_a     (clk_a),
        .arstn     (arstn),
        .bus       (bus)
`ifdef CDC_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk_b = ~clk_b;

    initial begin
        #2 clk_a = 1'b1;
        forever #17 clk_a = ~clk_a;
    end

    // collect delivered words and watch that dst_data only moves with dst_valid
    always @(negedge clk_a) begin
        if (arstn && bus.dst_valid) rx_q.push_back(bus.dst_data);
        if (arstn && have_prev && !bus.dst_valid && (bus.dst_data !== prev_dst)) viol++;
        prev_dst  = bus.dst_data;
        have_prev = arstn;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!bus.src_ready && k < 100) begin
            @(negedge clk_b);
            k++;
        end
        check(tag, bus.src_ready, 1);
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 300) begin
            @(negedge clk_a);
            k++;
        end
        repeat (6) @(negedge clk_a);
    endtask

    initial begin
        int  n;
        int  k;
        int  tmo;
        bit  found;

        bus.src_valid = 1'b0;
        bus.src_data  = 8'h00;

        // reset release
        repeat (3) @(negedge clk_b);
        brstn = 1'b1;
        @(negedge clk_a);
        arstn = 1'b1;
        @(negedge clk_b);
        check("rst_src_ready", bus.src_ready, 1);
        check("rst_dst_valid", bus.dst_valid, 0);
        check("rst_dst_data", bus.dst_data, 8'h00);
`ifdef CDC_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif

        // single transfer 0xA5 with latency measurement
        @(negedge clk_b);
        bus.src_valid = 1'b1;
        bus.src_data  = 8'hA5;
        @(posedge clk_b);
        #1;
        bus.src_valid = 1'b0;
        bus.src_data  = 8'h00;
        check("a5_ready_low", bus.src_ready, 0);
        n = 0;
        found = 1'b0;
        while (!found && n < 8) begin
            @(posedge clk_a);
            n++;
            @(negedge clk_a);
            if (bus.dst_valid) found = 1'b1;
        end
        check("a5_pulse_seen", found, 1);
        check("a5_latency_3_4", (n >= 3 && n <= 4), 1);
        check("a5_data", bus.dst_data, 8'hA5);
        @(negedge clk_a);
        check("a5_pulse_width", bus.dst_valid, 0);
        @(negedge clk_b);
        wait_ready("a5_ready_return");
        repeat (4) @(negedge clk_a);
        check("a5_pulse_count", rx_q.size(), 1);
`ifdef CDC_STALL_CNT_EN
        check("a5_stall_cnt", stall_cnt, 0);
`endif
        rx_q.delete();

        // stream 0x01..0x10, src_valid held high, data changes only on acceptance
        tmo = 0;
        for (int i = 1; i <= 16; i++) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 8'(i);
            k = 0;
            @(negedge clk_b);
            while (!bus.src_ready && k < 100) begin
                @(negedge clk_b);
                k++;
            end
            if (k >= 100) tmo++;
            @(posedge clk_b);
            #1;
        end
        bus.src_valid = 1'b0;
        check("stream_timeouts", tmo, 0);
        wait_rx(16);
        check("stream_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) check("stream_word", rx_q[i], 64'(i + 1));
        end
`ifdef CDC_STALL_CNT_EN
        check("stall_saturated", stall_cnt, 15);
`endif
        rx_q.delete();

        // data toggling 0x11/0x22 while busy: only the accepted 0x11 arrives
        @(negedge clk_b);
        wait_ready("tgl_ready_start");
        bus.src_valid = 1'b1;
        bus.src_data  = 8'h11;
        @(posedge clk_b);
        #1;
        k = 0;
        while (k < 100) begin
            @(negedge clk_b);
            if (bus.src_ready) break;
            bus.src_data = (bus.src_data == 8'h11) ? 8'h22 : 8'h11;
            k++;
        end
        bus.src_valid = 1'b0;
        check("tgl_ready_return", bus.src_ready, 1);
        wait_rx(1);
        check("tgl_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("tgl_word", rx_q[0], 8'h11);
        check("tgl_dst_hold", bus.dst_data, 8'h11);
        check("dst_stable_1", viol, 0);
        rx_q.delete();

        // reset both domains in the middle of a BUSY window
        @(negedge clk_b);
        bus.src_valid = 1'b1;
        bus.src_data  = 8'h77;
        @(posedge clk_b);
        #1;
        bus.src_valid = 1'b0;
        @(negedge clk_b);
        check("mid_busy", bus.src_ready, 0);
        brstn = 1'b0;
        arstn = 1'b0;
        #1;
        check("mrst_src_ready", bus.src_ready, 1);
        check("mrst_dst_valid", bus.dst_valid, 0);
        check("mrst_dst_data", bus.dst_data, 8'h00);
`ifdef CDC_STALL_CNT_EN
        check("mrst_stall_cnt", stall_cnt, 0);
`endif
        repeat (3) @(negedge clk_a);
        rx_q.delete();
        @(negedge clk_b);
        brstn = 1'b1;
        @(negedge clk_a);
        arstn = 1'b1;
        @(negedge clk_b);
        check("post_rst_ready", bus.src_ready, 1);
        bus.src_valid = 1'b1;
        bus.src_data  = 8'h3C;
        @(posedge clk_b);
        #1;
        bus.src_valid = 1'b0;
        check("3c_ready_low", bus.src_ready, 0);
        wait_rx(1);
        check("3c_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("3c_word", rx_q[0], 8'h3C);
        check("3c_dst_data", bus.dst_data, 8'h3C);
        @(negedge clk_b);
        wait_ready("3c_ready_return");
        check("dst_stable_2", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
